// File: rtl/csel_adder_pipe_pkg.sv
// Shared defaults and configuration check for the carry-select adder pipeline.
package csel_adder_pipe_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefBlk   = 4;

  // True when the width splits into whole blocks of at least one bit.
  function automatic bit blk_cfg_ok(int unsigned width, int unsigned blk);
    if (blk < 1) return 1'b0;
    return (width % blk == 0) && (width >= blk);
  endfunction

endpackage

// File: rtl/csel_adder_pipe_if.sv
// Operand/result handshake bundle for csel_adder_pipe.
interface csel_adder_pipe_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side driving operands and accepting results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/csel_adder_pipe_csel_block.sv
// Carry-select block: sums a BLK-bit slice for both possible carry-ins.
module csel_block #(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  output logic [BLK-1:0] s0_o,
  output logic [BLK-1:0] s1_o,
  output logic           c0_o,
  output logic           c1_o
);

  logic [BLK:0] carry0;
  logic [BLK:0] carry1;

  assign carry0[0] = 1'b0;
  assign carry1[0] = 1'b1;

  for (genvar i = 0; i < BLK; i++) begin : g_bit
    fa u_fa0 (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry0[i]),
      .s_o (s0_o[i]),
      .c_o (carry0[i+1])
    );
    fa u_fa1 (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry1[i]),
      .s_o (s1_o[i]),
      .c_o (carry1[i+1])
    );
  end

  assign c0_o = carry0[BLK];
  assign c1_o = carry1[BLK];

endmodule

// File: rtl/csel_adder_pipe_fa.sv
// One-bit full adder cell.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 precomputes per-block sums for both carry-ins; stage 2 resolves the block
// carry chain through muxes and registers the result.
module csel_adder_pipe
  import csel_adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned BLK   = DefBlk
) (
  input  logic             clk,
  input  logic             rst,
  csel_adder_pipe_if.slave bus_io
);

  localparam int unsigned NBLK = WIDTH / BLK;

  if (!blk_cfg_ok(WIDTH, BLK)) begin : g_cfg_err
    $fatal(1, "csel_adder_pipe: WIDTH must be a non-zero multiple of BLK >= 1");
  end

  logic             en1, en2, accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  logic             s1_valid_q;
  logic [BLK-1:0]   lo_sum_d, lo_sum_q;
  logic             lo_c_q;
  logic [BLK:0]     lo_carry;
  logic             a_msb_q, beff_msb_q;

  logic [NBLK-1:0]  sel;
  logic [WIDTH-1:0] res;
  logic             ovf_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  // Handshake enables and effective operands; subtract forces carry-in to 1.
  always_comb begin
    en2    = !out_valid_q || bus_io.out_ready;
    en1    = !s1_valid_q || en2;
    accept = bus_io.in_valid && en1;
    b_eff  = bus_io.sub ? ~bus_io.b : bus_io.b;
    c_eff  = bus_io.sub | bus_io.cin;
  end

  assign bus_io.in_ready = en1;

  // Block 0 sees the real carry-in, so a single ripple chain suffices.
  assign lo_carry[0] = c_eff;
  for (genvar i = 0; i < BLK; i++) begin : g_lo
    fa u_fa (
      .a_i (bus_io.a[i]),
      .b_i (b_eff[i]),
      .c_i (lo_carry[i]),
      .s_o (lo_sum_d[i]),
      .c_o (lo_carry[i+1])
    );
  end

  // Stage 1 control and block-0/MSB capture; data only loads on an accepted operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      lo_sum_q   <= '0;
      lo_c_q     <= 1'b0;
      a_msb_q    <= 1'b0;
      beff_msb_q <= 1'b0;
    end else if (en1) begin
      s1_valid_q <= accept;
      if (accept) begin
        lo_sum_q   <= lo_sum_d;
        lo_c_q     <= lo_carry[BLK];
        a_msb_q    <= bus_io.a[WIDTH-1];
        beff_msb_q <= b_eff[WIDTH-1];
      end
    end
  end

  assign sel[0]        = lo_c_q;
  assign res[BLK-1:0]  = lo_sum_q;

  if (NBLK > 1) begin : g_sel
    logic [WIDTH-1:BLK] hi0_d, hi1_d, hi0_q, hi1_q;
    logic [NBLK-1:1]    c0_d, c1_d, c0_q, c1_q;

    for (genvar k = 1; k < NBLK; k++) begin : g_blk
      csel_block #(
        .BLK (BLK)
      ) u_blk (
        .a_i  (bus_io.a[k*BLK +: BLK]),
        .b_i  (b_eff[k*BLK +: BLK]),
        .s0_o (hi0_d[k*BLK +: BLK]),
        .s1_o (hi1_d[k*BLK +: BLK]),
        .c0_o (c0_d[k]),
        .c1_o (c1_d[k])
      );

      // Carry select: the previous block's resolved carry picks this block's pair.
      assign sel[k]              = sel[k-1] ? c1_q[k] : c0_q[k];
      assign res[k*BLK +: BLK]   = sel[k-1] ? hi1_q[k*BLK +: BLK] : hi0_q[k*BLK +: BLK];
    end

    // Stage 1 capture of the speculative upper-block results.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hi0_q <= '0;
        hi1_q <= '0;
        c0_q  <= '0;
        c1_q  <= '0;
      end else if (accept) begin
        hi0_q <= hi0_d;
        hi1_q <= hi1_d;
        c0_q  <= c0_d;
        c1_q  <= c1_d;
      end
    end
  end

  assign ovf_d = (a_msb_q == beff_msb_q) && (res[WIDTH-1] != a_msb_q);

  // Stage 2 output register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= res;
        cout_q <= sel[NBLK-1];
        ovf_q  <= ovf_d;
      end
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.sum       = sum_q;
  assign bus_io.cout      = cout_q;
  assign bus_io.ovf       = ovf_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed and random checks of csel_adder_pipe at BLK = 4, 1 and 16 in lockstep.
module tb_csel_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, cin, sub, out_ready;
  logic [15:0] a, b;

  always #5 clk = ~clk;

  csel_adder_pipe_if #(.WIDTH(16)) if4 ();
  csel_adder_pipe_if #(.WIDTH(16)) if1 ();
  csel_adder_pipe_if #(.WIDTH(16)) if16 ();

  assign if4.in_valid  = in_valid;  assign if1.in_valid  = in_valid;  assign if16.in_valid  = in_valid;
  assign if4.a         = a;         assign if1.a         = a;         assign if16.a         = a;
  assign if4.b         = b;         assign if1.b         = b;         assign if16.b         = b;
  assign if4.cin       = cin;       assign if1.cin       = cin;       assign if16.cin       = cin;
  assign if4.sub       = sub;       assign if1.sub       = sub;       assign if16.sub       = sub;
  assign if4.out_ready = out_ready; assign if1.out_ready = out_ready; assign if16.out_ready = out_ready;

  csel_adder_pipe #(.WIDTH(16), .BLK(4))  dut4  (.clk(clk), .rst(rst), .bus_io(if4));
  csel_adder_pipe #(.WIDTH(16), .BLK(1))  dut1  (.clk(clk), .rst(rst), .bus_io(if1));
  csel_adder_pipe #(.WIDTH(16), .BLK(16)) dut16 (.clk(clk), .rst(rst), .bus_io(if16));

  logic        o_vld [3];
  logic        o_rdy [3];
  logic        o_cout[3];
  logic        o_ovf [3];
  logic [15:0] o_sum [3];

  assign o_vld[0] = if4.out_valid; assign o_vld[1] = if1.out_valid; assign o_vld[2] = if16.out_valid;
  assign o_rdy[0] = if4.in_ready;  assign o_rdy[1] = if1.in_ready;  assign o_rdy[2] = if16.in_ready;
  assign o_cout[0] = if4.cout;     assign o_cout[1] = if1.cout;     assign o_cout[2] = if16.cout;
  assign o_ovf[0] = if4.ovf;       assign o_ovf[1] = if1.ovf;       assign o_ovf[2] = if16.ovf;
  assign o_sum[0] = if4.sum;       assign o_sum[1] = if1.sum;       assign o_sum[2] = if16.sum;

  int total = 0;
  int bad   = 0;

  // Reference: {ovf, cout, sum} from a + b_eff + c_eff.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [15:0] be;
    logic [16:0] r;
    logic        v;
    be = ms ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, be} + {16'b0, (ms | mc)};
    v  = (ma[15] == be[15]) && (r[15] != ma[15]);
    return {v, r};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = 1'b0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      total++;
      if ({o_vld[j], o_cout[j], o_ovf[j], o_sum[j]} !== 19'h0) begin
        bad++;
        $display("FAIL reset_outputs inst%0d got vld=%b cout=%b ovf=%b sum=%h want all 0",
                 j, o_vld[j], o_cout[j], o_ovf[j], o_sum[j]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      total++;
      if (o_rdy[j] !== 1'b1) begin
        bad++;
        $display("FAIL reset_in_ready inst%0d got=%b want=1", j, o_rdy[j]);
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta[6], tb_[6], es[6];
    logic        tc[6], ts[6], ec[6], eo[6];
    ta  = '{16'hFFFF, 16'h000F, 16'h7FFF, 16'h8000, 16'h0003, 16'h0005};
    tb_ = '{16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0005, 16'h0003};
    tc  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ts  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    es  = '{16'h0000, 16'h0010, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h0002};
    ec  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    eo  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      a = ta[v]; b = tb_[v]; cin = tc[v]; sub = ts[v];
      @(negedge clk);
      in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; sub = 1'b0;
      for (int j = 0; j < 3; j++) begin
        total++;
        if (o_vld[j] !== 1'b0) begin
          bad++;
          $display("FAIL dir%0d_early_valid inst%0d got=%b want=0", v, j, o_vld[j]);
        end
      end
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        total++;
        if ({o_vld[j], o_cout[j], o_ovf[j], o_sum[j]} !== {1'b1, ec[v], eo[v], es[v]}) begin
          bad++;
          $display("FAIL dir%0d_result inst%0d got vld=%b cout=%b ovf=%b sum=%h want 1 %b %b %h",
                   v, j, o_vld[j], o_cout[j], o_ovf[j], o_sum[j], ec[v], eo[v], es[v]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_sum[3];
    exp_sum = '{16'd3, 16'd7, 16'd11};
    out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; a = 16'd1; b = 16'd2;
    @(negedge clk);
    a = 16'd3; b = 16'd4;
    @(negedge clk);
    a = 16'd5; b = 16'd6;
    for (int h = 0; h < 2; h++) begin
      for (int j = 0; j < 3; j++) begin
        total++;
        if ({o_rdy[j], o_vld[j], o_sum[j]} !== {1'b0, 1'b1, 16'd3}) begin
          bad++;
          $display("FAIL bp_hold%0d inst%0d got rdy=%b vld=%b sum=%h want 0 1 0003",
                   h, j, o_rdy[j], o_vld[j], o_sum[j]);
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      total++;
      if (o_rdy[j] !== 1'b1) begin
        bad++;
        $display("FAIL bp_ready_pass inst%0d got=%b want=1", j, o_rdy[j]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int r = 1; r < 3; r++) begin
      for (int j = 0; j < 3; j++) begin
        total++;
        if ({o_vld[j], o_sum[j]} !== {1'b1, exp_sum[r]}) begin
          bad++;
          $display("FAIL bp_drain%0d inst%0d got vld=%b sum=%h want 1 %h",
                   r, j, o_vld[j], o_sum[j], exp_sum[r]);
        end
      end
      @(negedge clk);
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (o_vld[j] !== 1'b0) begin
        bad++;
        $display("FAIL bp_empty inst%0d got=%b want=0", j, o_vld[j]);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; a = 16'd1; b = 16'd2;
    @(negedge clk);
    a = 16'd3; b = 16'd4;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      total++;
      if ({o_vld[j], o_sum[j]} !== 17'h0) begin
        bad++;
        $display("FAIL arst_immediate inst%0d got vld=%b sum=%h want 0 0000", j, o_vld[j], o_sum[j]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        total++;
        if ({o_rdy[j], o_vld[j]} !== 2'b10) begin
          bad++;
          $display("FAIL arst_stale%0d inst%0d got rdy=%b vld=%b want 1 0", c, j, o_rdy[j], o_vld[j]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [17:0] q[$];
    logic [17:0] exp;
    int          pops = 0;
    for (int it = 0; it < 600; it++) begin
      @(negedge clk);
      if (it < 560) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      if (o_vld[0] && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL rnd_extra it=%0d got vld=1 sum=%h want no result", it, o_sum[0]);
        end else begin
          exp = q.pop_front();
          pops++;
          for (int j = 0; j < 3; j++) begin
            total++;
            if ({o_vld[j], o_ovf[j], o_cout[j], o_sum[j]} !== {1'b1, exp}) begin
              bad++;
              $display("FAIL rnd_result it=%0d inst%0d got vld=%b ovf=%b cout=%b sum=%h want 1 %b %b %h",
                       it, j, o_vld[j], o_ovf[j], o_cout[j], o_sum[j], exp[17], exp[16], exp[15:0]);
            end
          end
        end
      end
      if (in_valid && o_rdy[0]) q.push_back(model(a, b, cin, sub));
    end
    total++;
    if (q.size() != 0 || pops == 0) begin
      bad++;
      $display("FAIL rnd_count got pending=%0d popped=%0d want pending=0 popped>0", q.size(), pops);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
